// File: rtl/ad_cache_reader_if.sv
// Cache-read and framed-stream signals of the AD cache reader.
// master = the reader; slave = the cache plus the downstream consumer.
interface ad_cache_reader_if #(
   parameter int DATA_NBIT = 16
);
   logic                 switch;
   logic                 rd;
   logic [DATA_NBIT-1:0] rdata;
   logic [DATA_NBIT-1:0] m_data;
   logic                 m_valid;
   logic                 m_last;
   logic                 m_ready;

   modport master (
      input  switch,
      input  rdata,
      input  m_ready,
      output rd,
      output m_data,
      output m_valid,
      output m_last
   );

   modport slave (
      output switch,
      output rdata,
      output m_ready,
      input  rd,
      input  m_data,
      input  m_valid,
      input  m_last
   );
endinterface

// File: rtl/ad_cache_reader.sv
// Drains one cache half per switch into a framed stream: sync, frame number, samples, checksum.
// SYNC_WORD is visible two edges after switch; rd stalls against reserved FIFO space under back-pressure.
module ad_cache_reader #(
   parameter int                   DATA_NBIT = 16,
   parameter int                   FRAME_LEN = 1024,
   parameter int                   RD_LAT    = 2,
   parameter logic [DATA_NBIT-1:0] SYNC_WORD = 16'hEB90
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     en_i,
   ad_cache_reader_if.master        bus,
   output logic [15:0]              frame_cnt_o,
   output logic [7:0]               overrun_cnt_o
);

   localparam int DEPTH  = RD_LAT + 4;
   localparam int SDEPTH = DEPTH - 1;
   localparam int PW     = $clog2(SDEPTH);
   localparam int CW     = $clog2(DEPTH + 1);
   localparam int IW     = $clog2(FRAME_LEN + 1);

   typedef enum logic [2:0] {IDLE, HEAD, FNUM, DATA, DRAIN, CSUM} state_t;

   state_t               state_q, state_d;
   logic                 rd_q, rd_d;
   logic [IW-1:0]        issued_q, issued_d;
   logic [DATA_NBIT-1:0] csum_q, csum_d;
   logic                 pend_q, pend_d;
   logic [15:0]          frame_q, frame_d;
   logic [7:0]           ovr_q, ovr_d;
   logic [RD_LAT-1:0]    sr_q, sr_d;

   logic                 rd_fire;
   logic                 sw;
   logic                 flush;
   logic [CW-1:0]        occ;
   logic [CW-1:0]        free_slots;
   logic [CW-1:0]        inflight;
   logic                 push;
   logic                 push_last;
   logic [DATA_NBIT-1:0] push_dat;

   logic [DATA_NBIT-1:0] m_data_q;
   logic                 m_valid_q;
   logic                 m_last_q;
   logic [DATA_NBIT:0]   mem_q [SDEPTH];
   logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]        cnt_q;
   logic                 pop;
   logic                 load_out;
   logic                 take_mem;
   logic                 wr_mem;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(SDEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // The cache lets switch win over rd, so never present both in one cycle.
   assign bus.rd        = rd_q & ~bus.switch;
   assign rd_fire       = bus.rd;
   assign sw            = bus.switch & en_i;
   assign flush         = ~en_i;
   assign occ           = cnt_q + CW'(m_valid_q);
   assign free_slots    = CW'(DEPTH) - occ;
   assign frame_cnt_o   = frame_q;
   assign overrun_cnt_o = ovr_q;

   always_comb begin
      state_d   = state_q;
      rd_d      = 1'b0;
      issued_d  = issued_q + IW'(rd_fire);
      csum_d    = csum_q;
      pend_d    = pend_q;
      frame_d   = frame_q;
      ovr_d     = ovr_q;
      push      = 1'b0;
      push_last = 1'b0;
      push_dat  = bus.rdata;
      inflight  = CW'(rd_fire);
      sr_d      = '0;
      sr_d[0]   = rd_fire;
      for (int i = 0; i < RD_LAT; i++) begin
         inflight = inflight + CW'(sr_q[i]);
      end
      for (int i = 1; i < RD_LAT; i++) begin
         sr_d[i] = sr_q[i-1];
      end

      if (sr_q[RD_LAT-1]) begin
         push   = 1'b1;
         csum_d = csum_q + bus.rdata;
      end

      if (sw && (state_q != IDLE) && (ovr_q != 8'hFF)) begin
         ovr_d = ovr_q + 8'd1;
      end

      case (state_q)
         IDLE: begin
            if (sw) state_d = HEAD;
         end
         HEAD: begin
            if (occ < CW'(DEPTH)) begin
               push     = 1'b1;
               push_dat = SYNC_WORD;
               state_d  = FNUM;
            end
         end
         FNUM: begin
            if (occ < CW'(DEPTH)) begin
               push     = 1'b1;
               push_dat = DATA_NBIT'(frame_q);
               frame_d  = frame_q + 16'd1;
               csum_d   = '0;
               issued_d = '0;
               state_d  = DATA;
               // This cycle's header push also consumes a slot.
               rd_d     = (free_slots > CW'(1));
            end
         end
         DATA: begin
            if (sw) begin
               pend_d  = 1'b1;
               state_d = DRAIN;
            end else if (issued_d == IW'(FRAME_LEN)) begin
               state_d = DRAIN;
            end else begin
               rd_d = (free_slots > inflight);
            end
         end
         DRAIN: begin
            if (sw) pend_d = 1'b1;
            if (sr_q == '0) state_d = CSUM;
         end
         CSUM: begin
            if (occ < CW'(DEPTH)) begin
               push      = 1'b1;
               push_last = 1'b1;
               push_dat  = csum_q;
               if (pend_q || sw) begin
                  pend_d  = 1'b0;
                  state_d = HEAD;
               end else begin
                  state_d = IDLE;
               end
            end else if (sw) begin
               pend_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (flush) begin
         state_d  = IDLE;
         rd_d     = 1'b0;
         pend_d   = 1'b0;
         sr_d     = '0;
         push     = 1'b0;
         issued_d = issued_q;
         csum_d   = csum_q;
         frame_d  = frame_q;
         ovr_d    = ovr_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         rd_q     <= 1'b0;
         issued_q <= '0;
         csum_q   <= '0;
         pend_q   <= 1'b0;
         frame_q  <= '0;
         ovr_q    <= '0;
         sr_q     <= '0;
      end else begin
         state_q  <= state_d;
         rd_q     <= rd_d;
         issued_q <= issued_d;
         csum_q   <= csum_d;
         pend_q   <= pend_d;
         frame_q  <= frame_d;
         ovr_q    <= ovr_d;
         sr_q     <= sr_d;
      end
   end

   // Output register is the FIFO head; a push into an empty FIFO lands there directly.
   assign pop      = m_valid_q & bus.m_ready;
   assign load_out = ~m_valid_q | pop;
   assign take_mem = load_out & (cnt_q != '0);
   assign wr_mem   = push & ~(load_out & (cnt_q == '0));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         m_data_q  <= '0;
         m_valid_q <= 1'b0;
         m_last_q  <= 1'b0;
         cnt_q     <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
      end else if (flush) begin
         m_valid_q <= 1'b0;
         m_last_q  <= 1'b0;
         cnt_q     <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
      end else begin
         if (load_out) begin
            if (take_mem) begin
               {m_last_q, m_data_q} <= mem_q[rd_ptr_q];
               m_valid_q            <= 1'b1;
               rd_ptr_q             <= ptr_inc(rd_ptr_q);
            end else if (push) begin
               m_data_q  <= push_dat;
               m_last_q  <= push_last;
               m_valid_q <= 1'b1;
            end else begin
               m_valid_q <= 1'b0;
               m_last_q  <= 1'b0;
            end
         end
         if (wr_mem) wr_ptr_q <= ptr_inc(wr_ptr_q);
         cnt_q <= cnt_q + CW'(wr_mem) - CW'(take_mem);
      end
   end

   always_ff @(posedge clk) begin
      if (wr_mem) mem_q[wr_ptr_q] <= {push_last, push_dat};
   end

   assign bus.m_data  = m_data_q;
   assign bus.m_valid = m_valid_q;
   assign bus.m_last  = m_last_q;

endmodule

// File: tb/tb_ad_cache_reader.sv
// Bench for ad_cache_reader: cache model preloaded with 1..N, frame-level expected-word model.
module tb_ad_cache_reader;
   localparam int FL  = 8;
   localparam int LAT = 2;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic [15:0] frame_cnt;
   logic [7:0]  overrun_cnt;

   ad_cache_reader_if #(.DATA_NBIT(16)) bif ();

   ad_cache_reader #(
      .DATA_NBIT(16), .FRAME_LEN(FL), .RD_LAT(LAT), .SYNC_WORD(16'hEB90)
   ) dut (
      .clk(clk), .rst_n(rst_n), .en_i(en), .bus(bif),
      .frame_cnt_o(frame_cnt), .overrun_cnt_o(overrun_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cache: switch clears the address, rd advances it; data at address a is a+1.
   logic [15:0] addr;
   logic [15:0] pipe [LAT];
   int          rd_cnt;
   initial begin
      addr   = '0;
      rd_cnt = 0;
      for (int k = 0; k < LAT; k++) pipe[k] = '0;
   end
   always @(posedge clk) begin
      if (bif.switch) addr <= '0;
      else if (bif.rd) addr <= addr + 16'd1;
      if (bif.rd) rd_cnt <= rd_cnt + 1;
      pipe[0] <= addr + 16'd1;
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
   end
   assign bif.rdata = pipe[LAT-1];

   int          checks;
   int          fails;
   logic [16:0] exp_q [$];
   logic [15:0] cap_q [$];
   logic [15:0] m_fnum;
   logic        tog_en;
   logic        hold_pend;
   logic [16:0] hold_word;
   int          base;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         fails++;
         $display("FAIL %s: got %0h want %0h", name, act, want);
      end
   endtask

   // One frame as it must appear on the wire: sync, number, samples 1..n, sum of samples.
   task automatic exp_frame(input int nsamp);
      logic [15:0] s;
      s = '0;
      exp_q.push_back({1'b0, 16'hEB90});
      exp_q.push_back({1'b0, m_fnum});
      for (int i = 0; i < nsamp; i++) begin
         exp_q.push_back({1'b0, 16'(i + 1)});
         s = s + 16'(i + 1);
      end
      exp_q.push_back({1'b1, s});
      m_fnum = m_fnum + 16'd1;
   endtask

   function automatic logic [15:0] cap_at(input int i);
      return (i < cap_q.size()) ? cap_q[i] : 16'hxxxx;
   endfunction

   task automatic do_reset();
      rst_n      = 1'b0;
      en         = 1'b1;
      bif.switch = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      exp_q.delete();
      cap_q.delete();
      m_fnum = '0;
      base   = rd_cnt;
   endtask

   task automatic pulse_switch();
      bif.switch = 1'b1;
      @(posedge clk); #1;
      bif.switch = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
         @(posedge clk); #1;
      end
      chk("words_outstanding", 32'(exp_q.size()), 32'd0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic wait_reads(input int n);
      for (int i = 0; i < 60 && (rd_cnt - base) < n; i++) begin
         @(posedge clk); #1;
      end
      chk("reads_reached", 32'(rd_cnt - base), 32'(n));
   endtask

   initial begin
      checks     = 0;
      fails      = 0;
      bif.switch = 1'b0;
      bif.m_ready = 1'b1;
      en         = 1'b1;
      rst_n      = 1'b0;
      tog_en     = 1'b0;
      m_fnum     = '0;
      hold_pend  = 1'b0;
      hold_word  = '0;
      base       = 0;

      fork
         forever begin
            @(negedge clk);
            if (!rst_n) begin
               hold_pend = 1'b0;
            end else begin
               if (hold_pend) begin
                  checks++;
                  if (!bif.m_valid || {bif.m_last, bif.m_data} !== hold_word) begin
                     fails++;
                     $display("FAIL stall_hold: got v=%b %h want v=1 %h", bif.m_valid,
                              {bif.m_last, bif.m_data}, hold_word);
                  end
               end
               hold_pend = bif.m_valid && !bif.m_ready && en;
               hold_word = {bif.m_last, bif.m_data};
               if (bif.m_valid && bif.m_ready) begin
                  checks++;
                  if (exp_q.size() == 0) begin
                     fails++;
                     $display("FAIL word_extra: got %h last %b want none", bif.m_data, bif.m_last);
                  end else begin
                     logic [16:0] e;
                     e = exp_q.pop_front();
                     if ({bif.m_last, bif.m_data} !== e) begin
                        fails++;
                        $display("FAIL word: got %h last %b want %h last %b",
                                 bif.m_data, bif.m_last, e[15:0], e[16]);
                     end
                  end
                  cap_q.push_back(bif.m_data);
               end
               if (bif.switch) begin
                  checks++;
                  if (bif.rd !== 1'b0) begin
                     fails++;
                     $display("FAIL rd_with_switch: got rd=%b want 0", bif.rd);
                  end
               end
            end
         end
         forever begin
            @(posedge clk); #3;
            if (tog_en) bif.m_ready = ~bif.m_ready;
         end
      join_none

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_rd", 32'(bif.rd), 32'd0);
      chk("rst_valid", 32'(bif.m_valid), 32'd0);
      chk("rst_last", 32'(bif.m_last), 32'd0);
      chk("rst_data", 32'(bif.m_data), 32'd0);
      chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
      chk("rst_overrun", 32'(overrun_cnt), 32'd0);
      rst_n = 1'b1;

      // One frame, ready held high
      do_reset();
      pulse_switch();
      exp_frame(FL);
      wait_done(100);
      chk("t1_len", 32'(cap_q.size()), 32'd11);
      chk("t1_sync", 32'(cap_at(0)), 32'hEB90);
      chk("t1_fnum", 32'(cap_at(1)), 32'h0000);
      chk("t1_csum", 32'(cap_at(10)), 32'h0024);
      chk("t1_frame_cnt", 32'(frame_cnt), 32'd1);
      chk("t1_rd_count", 32'(rd_cnt - base), 32'd8);

      // Same frame with ready toggling 1-0-1-0
      do_reset();
      bif.m_ready = 1'b1;
      tog_en = 1'b1;
      pulse_switch();
      exp_frame(FL);
      wait_done(200);
      tog_en = 1'b0;
      @(posedge clk); #1;
      bif.m_ready = 1'b1;
      @(posedge clk); #1;
      chk("t2_len", 32'(cap_q.size()), 32'd11);
      chk("t2_csum", 32'(cap_at(10)), 32'h0024);
      chk("t2_rd_count", 32'(rd_cnt - base), 32'd8);
      chk("t2_empty", 32'(bif.m_valid), 32'd0);

      // Two frames, switches 20 cycles apart
      do_reset();
      pulse_switch();
      exp_frame(FL);
      repeat (19) @(posedge clk);
      #1;
      pulse_switch();
      exp_frame(FL);
      wait_done(100);
      chk("t3_fnum1", 32'(cap_at(12)), 32'h0001);
      chk("t3_overrun", 32'(overrun_cnt), 32'd0);
      chk("t3_frame_cnt", 32'(frame_cnt), 32'(m_fnum));

      // Switch during DATA after 3 reads: truncated frame, then a fresh one
      do_reset();
      pulse_switch();
      exp_frame(3);
      wait_reads(3);
      pulse_switch();
      exp_frame(FL);
      wait_done(100);
      chk("t4_trunc_csum", 32'(cap_at(5)), 32'h0006);
      chk("t4_next_sync", 32'(cap_at(6)), 32'hEB90);
      chk("t4_overrun", 32'(overrun_cnt), 32'd1);
      chk("t4_rd_count", 32'(rd_cnt - base), 32'd11);
      chk("t4_frame_cnt", 32'(frame_cnt), 32'd2);

      // en dropped mid-DATA, then a clean frame
      do_reset();
      pulse_switch();
      exp_frame(FL);
      wait_reads(2);
      en = 1'b0;
      @(posedge clk); #1;
      chk("t5_valid_off", 32'(bif.m_valid), 32'd0);
      chk("t5_rd_off", 32'(bif.rd), 32'd0);
      exp_q.delete();
      en = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      pulse_switch();
      exp_frame(FL);
      wait_done(100);
      chk("t5_fnum", 32'(cap_at(3)), 32'h0001);
      chk("t5_frame_cnt", 32'(frame_cnt), 32'd2);

      // Reset mid-frame
      do_reset();
      pulse_switch();
      exp_frame(FL);
      wait_reads(2);
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("t6_rd", 32'(bif.rd), 32'd0);
      chk("t6_valid", 32'(bif.m_valid), 32'd0);
      chk("t6_last", 32'(bif.m_last), 32'd0);
      chk("t6_data", 32'(bif.m_data), 32'd0);
      chk("t6_frame_cnt", 32'(frame_cnt), 32'd0);
      chk("t6_overrun", 32'(overrun_cnt), 32'd0);
      rst_n = 1'b1;
      exp_q.delete();
      cap_q.delete();
      m_fnum = '0;
      @(posedge clk); #1;
      pulse_switch();
      exp_frame(FL);
      wait_done(100);
      chk("t6_fnum", 32'(cap_at(1)), 32'h0000);
      chk("t6_frame_cnt_after", 32'(frame_cnt), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
